// File: rtl/bp_pkg.sv
// Shared branch-prediction types, constants and helpers.
// Used by the ID-stage resolve unit and the IF-stage prediction table.
package bp_pkg;

    localparam int N_REG   = 4;
    localparam int N_BITS  = $clog2(N_REG);
    localparam int IDX_LSB = 2;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    typedef struct packed {
        logic        v;
        logic [63:0] pc;
        logic        pt;
        logic [63:0] ptgt;
    } stage_t;

    typedef struct packed {
        logic              valid;
        logic [N_BITS-1:0] idx;
        logic              taken;
        logic [63:0]       target;
        logic              correct;
    } upd_t;

    function automatic logic [63:0] imm_b(input logic [31:0] inst);
        return {{52{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [N_BITS-1:0] bpt_idx(input logic [63:0] pc);
        return pc[IDX_LSB+N_BITS-1:IDX_LSB];
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-side bundle of the branch resolve unit.
// master: IF stage + prediction table; slave: resolve unit.
//   if_*       prediction carried with each fetch (master -> slave)
//   flush/redirect_pc  fetch redirect (slave -> master)
//   upd_*      registered prediction-table update (slave -> master)
interface branch_resolve_unit_if;
    import bp_pkg::*;

    logic              if_valid;
    logic [63:0]       if_pc;
    logic              if_pred_taken;
    logic [63:0]       if_pred_target;
    logic              flush;
    logic [63:0]       redirect_pc;
    logic              upd_valid;
    logic [N_BITS-1:0] upd_idx;
    logic              upd_taken;
    logic [63:0]       upd_target;
    logic              upd_correct;

    modport master (
        output if_valid, if_pc, if_pred_taken, if_pred_target,
        input  flush, redirect_pc,
        input  upd_valid, upd_idx, upd_taken, upd_target, upd_correct
    );

    modport slave (
        input  if_valid, if_pc, if_pred_taken, if_pred_target,
        output flush, redirect_pc,
        output upd_valid, upd_idx, upd_taken, upd_target, upd_correct
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter, sticks at all-ones.
// Ports: clk, arst_n (async low), inc_i, count_o.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage BEQ resolution: flush/redirect fetch, update predictor, count.
// Ports: clk, arst_n, bus (slave), stall, id_inst, id_rs1/2_data, cnt_*.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    branch_resolve_unit_if.slave   bus,
    input  logic                   stall,
    input  logic [31:0]            id_inst,
    input  logic [63:0]            id_rs1_data,
    input  logic [63:0]            id_rs2_data,
    output logic [CNT_W-1:0]       cnt_branches,
    output logic [CNT_W-1:0]       cnt_mispredicts
);

    stage_t      stage_q;
    stage_t      stage_d;
    upd_t        upd_q;
    upd_t        upd_d;

    logic        res_en;
    logic        is_beq;
    logic        act_taken;
    logic [63:0] tgt;
    logic [63:0] pc4;
    logic        mispred;
    logic        flush;
    logic        beq_res;

    // rs field bits are only needed by the register file
    logic        unused_inst;
    assign unused_inst = ^id_inst[24:15];

    assign res_en    = stage_q.v & ~stall;
    assign is_beq    = (id_inst[6:0] == OPC_BRANCH)
                     & (id_inst[14:12] == F3_BEQ);
    assign act_taken = (id_rs1_data == id_rs2_data);
    assign tgt       = stage_q.pc + imm_b(id_inst);
    assign pc4       = stage_q.pc + 64'd4;
    assign beq_res   = res_en & is_beq;

    // A predicted-taken non-branch is an alias hit in the table
    always_comb begin
        mispred = 1'b0;
        if (is_beq) begin
            mispred = (stage_q.pt != act_taken)
                    | (stage_q.pt & act_taken
                       & (stage_q.ptgt != tgt));
        end else begin
            mispred = stage_q.pt;
        end
    end

    assign flush = res_en & mispred;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d.v = 1'b0;
        end else if (!stall) begin
            stage_d.v    = bus.if_valid;
            stage_d.pc   = bus.if_pc;
            stage_d.pt   = bus.if_pred_taken;
            stage_d.ptgt = bus.if_pred_target;
        end
    end

    always_comb begin
        upd_d       = upd_q;
        upd_d.valid = beq_res;
        if (beq_res) begin
            upd_d.idx     = bpt_idx(stage_q.pc);
            upd_d.taken   = act_taken;
            upd_d.target  = tgt;
            upd_d.correct = ~mispred;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stage_q <= '0;
            upd_q   <= '0;
        end else begin
            stage_q <= stage_d;
            upd_q   <= upd_d;
        end
    end

    assign bus.flush       = flush;
    assign bus.redirect_pc = !flush ? 64'd0
                           : (is_beq & act_taken) ? tgt : pc4;
    assign bus.upd_valid   = upd_q.valid;
    assign bus.upd_idx     = upd_q.idx;
    assign bus.upd_taken   = upd_q.taken;
    assign bus.upd_target  = upd_q.target;
    assign bus.upd_correct = upd_q.correct;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_br (
        .clk     (clk),
        .arst_n  (arst_n),
        .inc_i   (beq_res),
        .count_o (cnt_branches)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_mp (
        .clk     (clk),
        .arst_n  (arst_n),
        .inc_i   (flush),
        .count_o (cnt_mispredicts)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit.
// Counters built at 4 bits so saturation is reachable.
module tb_branch_resolve_unit;

    localparam int CW = 4;
    localparam logic [31:0] ADD = 32'h002081B3;

    logic          clk;
    logic          arst_n;
    logic          stall;
    logic [31:0]   id_inst;
    logic [63:0]   id_rs1_data;
    logic [63:0]   id_rs2_data;
    logic [CW-1:0] cnt_br;
    logic [CW-1:0] cnt_mp;

    int n_run;
    int n_fail;

    branch_resolve_unit_if bus ();

    branch_resolve_unit #(.CNT_W(CW)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .bus             (bus),
        .stall           (stall),
        .id_inst         (id_inst),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .cnt_branches    (cnt_br),
        .cnt_mispredicts (cnt_mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] beq(input logic [12:0] imm,
                                        input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3,
                imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load one fetch into ID, then present its operands
    task automatic issue(input logic [63:0] pc, input logic pt,
                         input logic [63:0] ptgt, input logic [31:0] inst,
                         input logic [63:0] a, input logic [63:0] b);
        bus.if_valid       = 1'b1;
        bus.if_pc          = pc;
        bus.if_pred_taken  = pt;
        bus.if_pred_target = ptgt;
        tick();
        bus.if_valid       = 1'b0;
        id_inst            = inst;
        id_rs1_data        = a;
        id_rs2_data        = b;
        #1;
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        arst_n = 1'b0;
        stall  = 1'b0;
        id_inst = beq(13'd16, 3'b000);
        id_rs1_data = 64'd5;
        id_rs2_data = 64'd5;
        bus.if_valid = 1'b0;
        bus.if_pc = 64'h0;
        bus.if_pred_taken = 1'b0;
        bus.if_pred_target = 64'h0;
        #2;
        chk("rst_flush", 64'(bus.flush), 64'd0);
        chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
        chk("rst_cnt_br", 64'(cnt_br), 64'd0);
        #10 arst_n = 1'b1;
        tick();
        tick();
        chk("idle_flush", 64'(bus.flush), 64'd0);
        chk("idle_redirect", bus.redirect_pc, 64'd0);
        chk("idle_cnt_mp", 64'(cnt_mp), 64'd0);

        // BEQ taken, predicted not-taken
        issue(64'h100, 1'b0, 64'h0, beq(13'd16, 3'b000), 64'd5, 64'd5);
        chk("t2_flush", 64'(bus.flush), 64'd1);
        chk("t2_redirect", bus.redirect_pc, 64'h110);
        tick();
        chk("t2_upd_valid", 64'(bus.upd_valid), 64'd1);
        chk("t2_upd_idx", 64'(bus.upd_idx), 64'd0);
        chk("t2_upd_taken", 64'(bus.upd_taken), 64'd1);
        chk("t2_upd_target", bus.upd_target, 64'h110);
        chk("t2_upd_correct", 64'(bus.upd_correct), 64'd0);
        chk("t2_cnt_mp", 64'(cnt_mp), 64'd1);
        chk("t2_squashed", 64'(bus.flush), 64'd0);

        // BEQ not taken, predicted not-taken
        issue(64'h104, 1'b0, 64'h0, beq(13'd16, 3'b000), 64'd5, 64'd6);
        chk("t3_flush", 64'(bus.flush), 64'd0);
        chk("t3_redirect", bus.redirect_pc, 64'd0);
        tick();
        chk("t3_upd_valid", 64'(bus.upd_valid), 64'd1);
        chk("t3_upd_idx", 64'(bus.upd_idx), 64'd1);
        chk("t3_upd_taken", 64'(bus.upd_taken), 64'd0);
        chk("t3_upd_target", bus.upd_target, 64'h114);
        chk("t3_upd_correct", 64'(bus.upd_correct), 64'd1);
        chk("t3_cnt_br", 64'(cnt_br), 64'd2);
        chk("t3_cnt_mp", 64'(cnt_mp), 64'd1);
        tick();
        chk("t3_upd_pulse", 64'(bus.upd_valid), 64'd0);

        // Taken, stale predicted target
        issue(64'h100, 1'b1, 64'h200, beq(13'd16, 3'b000), 64'd9, 64'd9);
        chk("t4_flush", 64'(bus.flush), 64'd1);
        chk("t4_redirect", bus.redirect_pc, 64'h110);
        tick();
        chk("t4_upd_correct", 64'(bus.upd_correct), 64'd0);
        chk("t4_upd_taken", 64'(bus.upd_taken), 64'd1);
        chk("t4_cnt_mp", 64'(cnt_mp), 64'd2);

        // Taken, correct target
        issue(64'h10C, 1'b1, 64'h11C, beq(13'd16, 3'b000), 64'd9, 64'd9);
        chk("ok_flush", 64'(bus.flush), 64'd0);
        tick();
        chk("ok_upd_correct", 64'(bus.upd_correct), 64'd1);
        chk("ok_upd_idx", 64'(bus.upd_idx), 64'd3);
        chk("ok_cnt_br", 64'(cnt_br), 64'd4);

        // Alias hit on non-branch
        issue(64'h108, 1'b1, 64'h300, ADD, 64'd1, 64'd1);
        chk("t5_flush", 64'(bus.flush), 64'd1);
        chk("t5_redirect", bus.redirect_pc, 64'h10C);
        tick();
        chk("t5_upd_valid", 64'(bus.upd_valid), 64'd0);
        chk("t5_upd_hold", bus.upd_target, 64'h11C);
        chk("t5_cnt_mp", 64'(cnt_mp), 64'd3);
        chk("t5_cnt_br", 64'(cnt_br), 64'd4);

        // Non-BEQ branch (BNE) not predicted: no action
        issue(64'h110, 1'b0, 64'h0, beq(13'd16, 3'b001), 64'd1, 64'd1);
        chk("bne_flush", 64'(bus.flush), 64'd0);
        tick();
        chk("bne_upd_valid", 64'(bus.upd_valid), 64'd0);

        // Negative offset
        issue(64'h100, 1'b0, 64'h0, beq(13'h1FF8, 3'b000), 64'd3, 64'd3);
        chk("neg_redirect", bus.redirect_pc, 64'hF8);
        tick();
        // Wrap below zero
        issue(64'h0, 1'b0, 64'h0, beq(13'h1FFC, 3'b000), 64'd3, 64'd3);
        chk("wrap_redirect", bus.redirect_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("wrap_upd_target", bus.upd_target, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_cnt_br", 64'(cnt_br), 64'd6);
        chk("wrap_cnt_mp", 64'(cnt_mp), 64'd5);

        // Stall over a mispredicting BEQ
        issue(64'h100, 1'b0, 64'h0, beq(13'd16, 3'b000), 64'd7, 64'd7);
        stall = 1'b1;
        bus.if_valid = 1'b1;
        bus.if_pc = 64'h300;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_flush", 64'(bus.flush), 64'd0);
            tick();
            chk("stall_upd", 64'(bus.upd_valid), 64'd0);
        end
        bus.if_valid = 1'b0;
        stall = 1'b0;
        #1;
        chk("unstall_flush", 64'(bus.flush), 64'd1);
        chk("unstall_redirect", bus.redirect_pc, 64'h110);
        tick();
        chk("unstall_once", 64'(bus.flush), 64'd0);
        chk("unstall_upd", 64'(bus.upd_valid), 64'd1);
        chk("unstall_cnt_mp", 64'(cnt_mp), 64'd6);
        chk("unstall_cnt_br", 64'(cnt_br), 64'd7);

        // Reset while flush is high
        issue(64'h100, 1'b0, 64'h0, beq(13'd16, 3'b000), 64'd7, 64'd7);
        chk("pre_rst_flush", 64'(bus.flush), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_flush", 64'(bus.flush), 64'd0);
        chk("mid_rst_redirect", bus.redirect_pc, 64'd0);
        chk("mid_rst_cnt_mp", 64'(cnt_mp), 64'd0);
        chk("mid_rst_upd_target", bus.upd_target, 64'd0);
        arst_n = 1'b1;
        tick();
        chk("post_rst_flush", 64'(bus.flush), 64'd0);
        chk("post_rst_upd", 64'(bus.upd_valid), 64'd0);

        // Saturation: 17 mispredicting BEQs
        for (int i = 0; i < 17; i++) begin
            issue(64'h100, 1'b0, 64'h0, beq(13'd16, 3'b000), 64'd1, 64'd1);
            tick();
            if (i == 2) chk("sat_mid_cnt_mp", 64'(cnt_mp), 64'd3);
        end
        chk("sat_cnt_br", 64'(cnt_br), 64'd15);
        chk("sat_cnt_mp", 64'(cnt_mp), 64'd15);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
